// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared select encoding and state types for the 2:1 stream arbiter
package arb_pkg;

  // Select encoding shared with the downstream mux_2x1 sel input.
  typedef logic sel_t;

  localparam sel_t SEL_IN1 = 1'b0;
  localparam sel_t SEL_IN2 = 1'b1;

  localparam int BURST_W = 8;

  typedef logic [BURST_W-1:0] burst_cnt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic sel_t other_sel(input sel_t s);
    return (s == SEL_IN1) ? SEL_IN2 : SEL_IN1;
  endfunction

endpackage

// File: rtl/rr_picker_2.sv
// rtl/rr_picker_2.sv - combinational round-robin winner pick with bounded burst
module rr_picker_2
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 1
) (
  input  logic       in1_valid_i,
  input  logic       in2_valid_i,
  input  sel_t       last_sel_i,
  input  burst_cnt_t burst_cnt_i,
  output logic       win_valid_o,
  output sel_t       win_sel_o
);

  localparam burst_cnt_t MAX_B = burst_cnt_t'(MAX_BURST);

  logic burst_open;

  // A zero count means no burst is in progress, so contention falls to round-robin.
  assign burst_open = (burst_cnt_i != '0) && (burst_cnt_i < MAX_B);

  always_comb begin
    win_valid_o = in1_valid_i | in2_valid_i;
    win_sel_o   = SEL_IN1;
    if (in1_valid_i && in2_valid_i) begin
      win_sel_o = burst_open ? last_sel_i : other_sel(last_sel_i);
    end else if (in2_valid_i) begin
      win_sel_o = SEL_IN2;
    end
  end

endmodule

// File: rtl/stream_arb_2x1.sv
// rtl/stream_arb_2x1.sv - two-input valid/ready arbiter with a single registered output stage
module stream_arb_2x1
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output sel_t             out_sel,
  input  logic             out_ready
);

  localparam burst_cnt_t MAX_B = burst_cnt_t'(MAX_BURST);

  out_state_t       state_q;
  logic [WIDTH-1:0] out_data_q;
  sel_t             out_sel_q;
  sel_t             last_sel_q;
  burst_cnt_t       burst_cnt_q;
  burst_cnt_t       burst_cnt_d;

  logic             win_valid;
  sel_t             win_sel;
  logic             load_ok;
  logic             accept;
  logic [WIDTH-1:0] win_data;

  rr_picker_2 #(
    .MAX_BURST (MAX_BURST)
  ) u_picker (
    .in1_valid_i (in1_valid),
    .in2_valid_i (in2_valid),
    .last_sel_i  (last_sel_q),
    .burst_cnt_i (burst_cnt_q),
    .win_valid_o (win_valid),
    .win_sel_o   (win_sel)
  );

  assign load_ok  = (state_q == ST_EMPTY) || out_ready;
  assign accept   = rst_n && load_ok && win_valid;
  assign win_data = (win_sel == SEL_IN2) ? in2_data : in1_data;

  // rst_n gates the readies so nothing is offered to producers while reset is held.
  assign in1_ready = accept && (win_sel == SEL_IN1);
  assign in2_ready = accept && (win_sel == SEL_IN2);

  always_comb begin
    burst_cnt_d = 8'd1;
    if (win_sel == last_sel_q) begin
      burst_cnt_d = (burst_cnt_q < MAX_B) ? burst_cnt_q + 8'd1 : burst_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_sel_q   <= SEL_IN1;
      last_sel_q  <= SEL_IN2;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!accept && out_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (accept) begin
        out_data_q  <= win_data;
        out_sel_q   <= win_sel;
        last_sel_q  <= win_sel;
        burst_cnt_q <= burst_cnt_d;
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_2x1.sv
// tb/tb_stream_arb_2x1.sv - randomized self-checking bench for stream_arb_2x1
module tb_stream_arb_2x1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in1_valid = 1'b0;
  logic [7:0] in1_data = '0;
  logic       in2_valid = 1'b0;
  logic [7:0] in2_data = '0;
  logic       out_ready = 1'b0;

  logic       in1_ready_w [2];
  logic       in2_ready_w [2];
  logic       out_valid_w [2];
  logic [7:0] out_data_w  [2];
  logic       out_sel_w   [2];

  int checks = 0;
  int errors = 0;

  // Two instances run side by side on the same stimulus: strict alternation and burst of 3.
  int         mb   [2] = '{1, 3};
  bit         m_valid [2];
  logic [7:0] m_data  [2];
  bit         m_sel   [2];
  bit         m_last  [2];
  int         m_run   [2];

  always #5 clk = ~clk;

  stream_arb_2x1 #(.WIDTH(8), .MAX_BURST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready_w[0]),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready_w[0]),
    .out_valid(out_valid_w[0]), .out_data(out_data_w[0]), .out_sel(out_sel_w[0]),
    .out_ready(out_ready)
  );

  stream_arb_2x1 #(.WIDTH(8), .MAX_BURST(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready_w[1]),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready_w[1]),
    .out_valid(out_valid_w[1]), .out_data(out_data_w[1]), .out_sel(out_sel_w[1]),
    .out_ready(out_ready)
  );

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0;
      m_data[k]  = '0;
      m_sel[k]   = 0;
      m_last[k]  = 1;
      m_run[k]   = 0;
    end
  endfunction

  // Winner from the arbitration rules: -1 none, 0 in1, 1 in2; m_run counts consecutive grants.
  function automatic int model_winner(int k, bit v1, bit v2);
    if (v1 && !v2) return 0;
    if (v2 && !v1) return 1;
    if (!v1 && !v2) return -1;
    if (m_run[k] > 0 && m_run[k] < mb[k]) return int'(m_last[k]);
    return int'(!m_last[k]);
  endfunction

  task automatic step(input bit v1, input logic [7:0] d1, input bit v2, input logic [7:0] d2,
                      input bit ordy, input string tag);
    int w [2];
    bit acc [2];
    in1_valid = v1; in1_data = d1; in2_valid = v2; in2_data = d2; out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit lok;
      lok    = !m_valid[k] || ordy;
      w[k]   = model_winner(k, v1, v2);
      acc[k] = lok && (w[k] >= 0);
      checks += 2;
      if (in1_ready_w[k] !== (acc[k] && w[k] == 0)) begin
        errors++;
        $display("FAIL %s dut%0d in1_ready got %0b exp %0b", tag, k, in1_ready_w[k], acc[k] && w[k] == 0);
      end
      if (in2_ready_w[k] !== (acc[k] && w[k] == 1)) begin
        errors++;
        $display("FAIL %s dut%0d in2_ready got %0b exp %0b", tag, k, in2_ready_w[k], acc[k] && w[k] == 1);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        m_valid[k] = 1;
        m_data[k]  = (w[k] == 1) ? d2 : d1;
        m_sel[k]   = (w[k] == 1);
        m_run[k]   = (m_sel[k] == m_last[k]) ? m_run[k] + 1 : 1;
        m_last[k]  = m_sel[k];
      end else if (m_valid[k] && ordy) begin
        m_valid[k] = 0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (out_valid_w[k] !== m_valid[k]) begin
        errors++;
        $display("FAIL %s dut%0d out_valid got %0b exp %0b", tag, k, out_valid_w[k], m_valid[k]);
      end
      if (out_data_w[k] !== m_data[k]) begin
        errors++;
        $display("FAIL %s dut%0d out_data got %02h exp %02h", tag, k, out_data_w[k], m_data[k]);
      end
      if (out_sel_w[k] !== m_sel[k]) begin
        errors++;
        $display("FAIL %s dut%0d out_sel got %0b exp %0b", tag, k, out_sel_w[k], m_sel[k]);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in1_valid = 1; in2_valid = 1; in1_data = 8'h5A; in2_data = 8'hC3; out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (out_valid_w[k] !== 1'b0) begin errors++; $display("FAIL reset dut%0d out_valid got %0b exp 0", k, out_valid_w[k]); end
      if (out_data_w[k] !== 8'h00) begin errors++; $display("FAIL reset dut%0d out_data got %02h exp 00", k, out_data_w[k]); end
      if (out_sel_w[k] !== 1'b0) begin errors++; $display("FAIL reset dut%0d out_sel got %0b exp 0", k, out_sel_w[k]); end
      if (in1_ready_w[k] !== 1'b0) begin errors++; $display("FAIL reset dut%0d in1_ready got %0b exp 0", k, in1_ready_w[k]); end
      if (in2_ready_w[k] !== 1'b0) begin errors++; $display("FAIL reset dut%0d in2_ready got %0b exp 0", k, in2_ready_w[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(1, 8'h5A, 1, 8'hC3, 1, "reset_first");
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_sel_w[k] !== 1'b0) begin errors++; $display("FAIL reset_first_sel dut%0d got %0b exp 0", k, out_sel_w[k]); end
    end
  endtask

  task automatic test_contention();
    bit pat3 [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 8'h11, 1, 8'h22, 1, "contention");
      checks += 3;
      if (out_data_w[0] !== ((i % 2 == 0) ? 8'h11 : 8'h22)) begin
        errors++;
        $display("FAIL alternate beat%0d got %02h exp %02h", i, out_data_w[0], (i % 2 == 0) ? 8'h11 : 8'h22);
      end
      if (out_sel_w[1] !== pat3[i]) begin
        errors++;
        $display("FAIL burst3 beat%0d out_sel got %0b exp %0b", i, out_sel_w[1], pat3[i]);
      end
      if (out_valid_w[0] !== 1'b1) begin
        errors++;
        $display("FAIL throughput beat%0d out_valid got %0b exp 1", i, out_valid_w[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step(1, 8'hA5, 0, 8'h00, 1, "bp_load");
    for (int i = 0; i < 4; i++) begin
      step(1, 8'($urandom), 1, 8'($urandom), 0, "bp_stall");
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (out_data_w[k] !== 8'hA5) begin errors++; $display("FAIL bp_hold dut%0d out_data got %02h exp a5", k, out_data_w[k]); end
        if (out_sel_w[k] !== 1'b0) begin errors++; $display("FAIL bp_hold dut%0d out_sel got %0b exp 0", k, out_sel_w[k]); end
      end
    end
    step(1, 8'h3C, 1, 8'hC3, 1, "bp_release");
    checks++;
    if (out_data_w[0] !== 8'hC3) begin errors++; $display("FAIL bp_release dut0 out_data got %02h exp c3", out_data_w[0]); end
  endtask

  task automatic test_single_source();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      step(0, 8'hEE, 1, 8'(i), 1, "single_in2");
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (out_data_w[k] !== 8'(i)) begin errors++; $display("FAIL single dut%0d out_data got %02h exp %02h", k, out_data_w[k], 8'(i)); end
        if (out_sel_w[k] !== 1'b1) begin errors++; $display("FAIL single dut%0d out_sel got %0b exp 1", k, out_sel_w[k]); end
      end
    end
    step(1, 8'h77, 0, 8'h00, 1, "single_in1");
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_sel_w[k] !== 1'b0) begin errors++; $display("FAIL single_switch dut%0d out_sel got %0b exp 0", k, out_sel_w[k]); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), "random");
    end
  endtask

  task automatic test_mid_reset();
    step(1, 8'h3C, 0, 8'h00, 0, "midrst_fill");
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid_w[k] !== 1'b0) begin errors++; $display("FAIL midrst_async dut%0d out_valid got %0b exp 0", k, out_valid_w[k]); end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(1, 8'h11, 1, 8'h22, 1, "midrst_after");
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_sel_w[k] !== 1'b0) begin errors++; $display("FAIL midrst_first dut%0d out_sel got %0b exp 0", k, out_sel_w[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_single_source();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
